piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-In Serial-Out transmitter that accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per clock on a single serial line, with frame markers. It is the transmit end of the 4-bit serial shift-register link and feeds a serial-in shift register or deserializer downstream. Back-to-back words are sent with no idle gap.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- LSB_FIRST, 0: 0 sends MSB first, 1 sends LSB first.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on an accepted load.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  serializer can accept a word this cycle (combinational from state/count).
- serial_out  output  1  registered serial data.
- frame_start  output  1  registered; high while serial_out carries bit 0 of a frame.
- frame_last  output  1  registered; high while serial_out carries the final bit of a frame.
- busy  output  1  registered; high while any frame bit is on serial_out.

## Operation
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-high.
- Reset values: serial_out=0, frame_start=0, frame_last=0, busy=0, state=IDLE, bit count=0, shift register=0, so load_ready=1 after reset.
- Accept: a load happens on a rising edge with load_valid && load_ready. data_in is captured into the shift register, and the bit counter is cleared.
- States:
  - IDLE: serial_out=0, busy=0, load_ready=1. On accept, go to SHIFT.
  - SHIFT: one bit per cycle in the selected order, with bit count 0..WIDTH-1.
    - At count WIDTH-1 without parity: go to IDLE, or stay in SHIFT with the new word if a load is accepted that cycle.
    - At count WIDTH-1 with parity: go to PARITY.
  - PARITY: present only when the macro is defined; see Configuration.
- load_ready = IDLE, or the final bit of the current frame is on serial_out. At all other times it is 0.
- load_valid while load_ready=0 is ignored and does not corrupt the frame. The producer must hold data_in and load_valid until acceptance.
- Bit order:
  - LSB_FIRST=0: serial_out = shift_reg[WIDTH-1], shift left, fill with 0.
  - LSB_FIRST=1: serial_out = shift_reg[0], shift right, fill with 0.
- Reset mid-frame: outputs return to reset values immediately. The partial frame is abandoned and never resumed.

## Timing
- Latency: the first bit appears on serial_out in the cycle after the accepting edge, with frame_start=1 and busy=1.
- Frame length is WIDTH cycles without parity, WIDTH+1 cycles with parity.
- frame_start is high for exactly 1 cycle per frame. frame_last is high for exactly 1 cycle per frame.
- With WIDTH=2, frame_start and frame_last fall in consecutive cycles. frame_start and frame_last are never high together.
- Back-to-back: a load accepted on the final-bit cycle puts the new frame's bit 0 in the next cycle. busy stays 1 and there is no gap.
- Throughput: one word per WIDTH (or WIDTH+1) cycles when load_valid is held high.
- After the final bit with no new load, the next cycle shows serial_out=0 and busy=0.

## Configuration
- PISO_PARITY_EN defined: an even-parity bit (XOR of all WIDTH data bits) is appended in state PARITY after the last data bit.
  - frame_last is asserted on the parity bit, not on the last data bit.
  - load_ready is asserted during the parity cycle.
  - The parity value is captured at load time.
- PISO_PARITY_EN undefined: there is no PARITY state, frames are exactly WIDTH bits, and frame_last falls on the last data bit.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> serial_out=0, busy=0, frame_start=0, frame_last=0, load_ready=1 immediately, with no clock edge needed.
- Single word, WIDTH=8, LSB_FIRST=0, data_in=8'hA5 -> serial_out 1,0,1,0,0,1,0,1 over cycles 1..8 after accept.
  - frame_start in cycle 1, frame_last in cycle 8.
  - busy=0 and serial_out=0 in cycle 9.
- LSB_FIRST=1, data_in=8'h01 -> serial_out 1,0,0,0,0,0,0,0. Back-to-back 8'hFF then 8'h00 with load_valid held high -> 16 contiguous bits (eight 1s, then eight 0s), busy=1 throughout, two frame_start pulses 8 cycles apart.
- Load while busy: pulse load_valid with 8'h3C during bit 3 of an 8'hA5 frame -> no accept, the A5 bit sequence is unchanged, and load_ready is first high on bit 8.
- Reset mid-frame: assert reset at bit 4 of 8'hF0, release it, then load 8'h81 -> outputs clear at once, and the next frame is exactly 1,0,0,0,0,0,0,1 with frame_start in its first cycle.
- With PISO_PARITY_EN:
  - 8'h07 -> bits 0,0,0,0,0,1,1,1, then parity 1, with frame_last on cycle 9.
  - 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake between a word producer and the
// serializer. The producer (master) drives data_in/load_valid; the
// serializer (slave) answers with load_ready.
interface piso_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (output data_in, output load_valid, input load_ready);
    modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter with frame markers.
// A word accepted through the load handshake is emitted one bit per clock on
// serial_out, MSB or LSB first, with frame_start on bit 0 and frame_last on
// the final bit. A new word may be accepted on the final-bit cycle so frames
// run back to back without a gap.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to every
// frame (frame length WIDTH+1, frame_last moves onto the parity bit).
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    piso_serializer_if.slave    bus,
    output logic                serial_out,
    output logic                frame_start,
    output logic                frame_last,
    output logic                busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  PREV_CNT = CNT_W'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   shift_d;
    logic               load_ready;
    logic               accept;
    logic               at_last;
    logic               start_d;
    logic               last_d;
    logic               busy_d;
`ifdef PISO_PARITY_EN
    logic               parity_bit;
`endif

    assign accept  = bus.load_valid && load_ready;
    assign at_last = (state == SHIFT) && (bit_cnt == LAST_CNT);

    assign bus.load_ready = load_ready;

    // The bit on the line is always the outgoing end of the shift register,
    // which only ever fills with zeros, so the line idles low for free.
    assign serial_out = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic: a frame ends on its final bit unless a new word is
    // accepted in that same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state;
        unique case (state)
            IDLE: begin
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                if (at_last) begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = accept ? SHIFT : IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Output logic: load_ready plus the next values of the registered
    // frame markers and the next shift-register contents.
    always_comb begin
        load_ready = 1'b0;
        start_d    = 1'b0;
        last_d     = 1'b0;
        busy_d     = 1'b0;
        shift_d    = LSB_FIRST ? {1'b0, shift_reg[WIDTH-1:1]}
                               : {shift_reg[WIDTH-2:0], 1'b0};
`ifdef PISO_PARITY_EN
        load_ready = (state == IDLE) || (state == PARITY);
        busy_d     = accept || (state == SHIFT);
        last_d     = at_last;
        // The parity bit takes the place of the data bit just shifted out.
        if (at_last) begin
            shift_d = LSB_FIRST ? {{(WIDTH-1){1'b0}}, parity_bit}
                                : {parity_bit, {(WIDTH-1){1'b0}}};
        end
`else
        load_ready = (state == IDLE) || at_last;
        busy_d     = accept || ((state == SHIFT) && !at_last);
        last_d     = (state == SHIFT) && (bit_cnt == PREV_CNT);
`endif
        start_d    = accept;
        if (accept) begin
            shift_d = bus.data_in;
        end
    end

    // Datapath and registered frame markers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_start <= 1'b0;
            frame_last  <= 1'b0;
            busy        <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            shift_reg   <= shift_d;
            frame_start <= start_d;
            frame_last  <= last_d;
            busy        <= busy_d;
            if (accept) begin
                bit_cnt <= '0;
`ifdef PISO_PARITY_EN
                parity_bit <= ^bus.data_in;
`endif
            end else if (state == SHIFT) begin
                bit_cnt <= at_last ? '0 : bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed bench for piso_serializer. Two instances share
// clk/reset: u_msb (LSB_FIRST=0) and u_lsb (LSB_FIRST=1). Expected bit
// sequences are written out by hand, first bit on the left.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic clk;
    logic reset;
    logic ser_m, start_m, last_m, busy_m;
    logic ser_l, start_l, last_l, busy_l;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    piso_serializer_if #(.WIDTH(8)) if_m ();
    piso_serializer_if #(.WIDTH(8)) if_l ();

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .bus         (if_m),
        .serial_out  (ser_m),
        .frame_start (start_m),
        .frame_last  (last_m),
        .busy        (busy_m)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .bus         (if_l),
        .serial_out  (ser_l),
        .frame_start (start_l),
        .frame_last  (last_l),
        .busy        (busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit lsb, input logic [7:0] d, input logic v);
        if (lsb) begin
            if_l.data_in    = d;
            if_l.load_valid = v;
        end else begin
            if_m.data_in    = d;
            if_m.load_valid = v;
        end
    endtask

    task automatic chk_all(input string tag, input bit lsb, input logic s,
                           input logic st, input logic la, input logic bu,
                           input logic rd);
        chk({tag, " serial"}, lsb ? ser_l   : ser_m,   s);
        chk({tag, " start"},  lsb ? start_l : start_m, st);
        chk({tag, " last"},   lsb ? last_l  : last_m,  la);
        chk({tag, " busy"},   lsb ? busy_l  : busy_m,  bu);
        chk({tag, " ready"},  lsb ? if_l.load_ready : if_m.load_ready, rd);
    endtask

    // One frame from IDLE: seq holds the hand-written bit order (seq[7]
    // goes first), par the expected parity bit, pulse_at the bit index
    // during which a rejected 8'h3C load is offered (0 = none).
    task automatic run_frame(input string name, input bit lsb,
                             input logic [7:0] d, input logic [7:0] seq,
                             input logic par, input int pulse_at);
        drive(lsb, d, 1'b1);
        step();
        drive(lsb, d, 1'b0);
        for (int k = 1; k <= FLEN; k++) begin
            chk_all($sformatf("%s b%0d", name, k), lsb,
                    (k <= 8) ? seq[8-k] : par,
                    k == 1, k == FLEN, 1'b1, k == FLEN);
            if (k == pulse_at) drive(lsb, 8'h3C, 1'b1);
            step();
            if (k == pulse_at) drive(lsb, d, 1'b0);
        end
        chk_all({name, " idle"}, lsb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h00, 1'b0);

        // Asynchronous reset, checked before any clock edge.
        #3 reset = 1'b1;
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("reset_l", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        reset = 1'b0;
        step();

        // Single words, both bit orders.
        run_frame("a5_msb", 1'b0, 8'hA5, 8'b1010_0101, 1'b0, 0);
        run_frame("01_lsb", 1'b1, 8'h01, 8'b1000_0000, 1'b1, 0);

        // Back-to-back FF then 00 with load_valid held high.
        drive(1'b1, 8'hFF, 1'b1);
        step();
        drive(1'b1, 8'h00, 1'b1);
        for (int k = 1; k <= 2 * FLEN; k++) begin
            chk_all($sformatf("b2b c%0d", k), 1'b1, k <= 8,
                    (k == 1) || (k == FLEN + 1),
                    (k == FLEN) || (k == 2 * FLEN),
                    1'b1, (k == FLEN) || (k == 2 * FLEN));
            step();
            if (k == FLEN) drive(1'b1, 8'h00, 1'b0);
        end
        chk_all("b2b idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Load offered while busy is ignored.
        run_frame("a5_busy", 1'b0, 8'hA5, 8'b1010_0101, 1'b0, 3);

        // Reset in the middle of an F0 frame, then a clean 81 frame.
        drive(1'b0, 8'hF0, 1'b1);
        step();
        drive(1'b0, 8'hF0, 1'b0);
        step();
        step();
        step();
        chk("f0 b4 serial", ser_m, 1'b1);
        chk("f0 b4 busy", busy_m, 1'b1);
        #4 reset = 1'b1;
        #1;
        chk_all("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b0;
        step();
        chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("81_msb", 1'b0, 8'h81, 8'b1000_0001, 1'b0, 0);

`ifdef PISO_PARITY_EN
        // Parity value checks.
        run_frame("07_par", 1'b0, 8'h07, 8'b0000_0111, 1'b1, 0);
        run_frame("03_par", 1'b0, 8'h03, 8'b0000_0011, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
